// File: rtl/llc_req_sequencer.sv
// Upstream LLC request stage: FIFO-buffered trace commands presented one at a
// time, with hold-driven replay, local print handling and illegal-op filtering.
module llc_req_sequencer #(
  parameter int unsigned DEPTH      = 8,
  parameter int unsigned MAX_REPLAY = 4,
  parameter int unsigned IDLE_OP    = 7
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        in_valid,
  output logic        in_ready,
  input  logic [3:0]  in_op,
  input  logic [31:0] in_addr,
  output logic [31:0] llc_addr,
  output logic [31:0] llc_op,
  input  logic [31:0] llc_hold,
  output logic        print_req,
  output logic        busy,
  output logic [31:0] issue_cnt,
  output logic [31:0] replay_cnt,
  output logic [31:0] drop_cnt,
  output logic        replay_err
);

  localparam int unsigned AW = $clog2(DEPTH);
  localparam int unsigned CW = AW + 1;
  localparam int unsigned RW = $clog2(MAX_REPLAY + 1);

  typedef enum logic [1:0] {IDLE, ISSUE, CHECK} state_t;

  state_t          state, state_next;
  logic [35:0]     mem [DEPTH];
  logic [AW-1:0]   wr_ptr, rd_ptr;
  logic [CW-1:0]   count, count_next;
  logic [RW-1:0]   rcnt;

  logic [3:0]      head_op;
  logic [31:0]     head_addr;
  logic            empty, push, pop;
  logic            head_req, head_print, head_rpl, hold_on;
  logic            replay, abandon, drop_inc;

  // Head classification and next-state decode
  always_comb begin
    state_next = state;
    pop        = 1'b0;
    replay     = 1'b0;
    abandon    = 1'b0;
    head_op    = mem[rd_ptr][35:32];
    head_addr  = mem[rd_ptr][31:0];
    empty      = (count == '0);
    push       = in_valid && in_ready;
    head_req   = (head_op <= 4'd6) || (head_op == 4'd8);
    head_print = (head_op == 4'd9);
    head_rpl   = (head_op == 4'd0) || (head_op == 4'd1) ||
                 (head_op == 4'd2) || (head_op == 4'd5);
    hold_on    = (llc_hold == 32'd1);
    case (state)
      IDLE: begin
        if (!empty) begin
          if (head_req) state_next = ISSUE;
          else          pop        = 1'b1;
        end
      end
      ISSUE: state_next = CHECK;
      CHECK: begin
        if (head_rpl && hold_on && (rcnt < RW'(MAX_REPLAY))) begin
          replay     = 1'b1;
          state_next = ISSUE;
        end else begin
          pop        = 1'b1;
          abandon    = head_rpl && hold_on;
          state_next = IDLE;
        end
      end
      default: state_next = IDLE;
    endcase
    drop_inc   = ((state == IDLE) && pop && !head_print) || abandon;
    count_next = count + CW'(push) - CW'(pop);
  end

  // FIFO storage needs no reset; pointers and count define validity
  always_ff @(posedge clk) begin
    if (push) mem[wr_ptr] <= {in_op, in_addr};
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state      <= IDLE;
      wr_ptr     <= '0;
      rd_ptr     <= '0;
      count      <= '0;
      rcnt       <= '0;
      in_ready   <= 1'b0;
      busy       <= 1'b0;
      print_req  <= 1'b0;
      llc_op     <= 32'(IDLE_OP);
      llc_addr   <= '0;
      issue_cnt  <= '0;
      replay_cnt <= '0;
      drop_cnt   <= '0;
      replay_err <= 1'b0;
    end else begin
      state     <= state_next;
      count     <= count_next;
      in_ready  <= (count_next != CW'(DEPTH));
      busy      <= (count_next != '0) || (state_next != IDLE);
      print_req <= (state == IDLE) && pop && head_print;
      drop_cnt  <= drop_cnt + 32'(drop_inc);
      if (push) wr_ptr <= wr_ptr + AW'(1);
      if (pop)  rd_ptr <= rd_ptr + AW'(1);
      case (state)
        IDLE: begin
          if (state_next == ISSUE) begin
            llc_op   <= 32'(head_op);
            llc_addr <= head_addr;
            rcnt     <= '0;
          end
        end
        ISSUE: begin
          issue_cnt <= issue_cnt + 32'd1;
          llc_op    <= 32'(IDLE_OP);
        end
        CHECK: begin
          if (replay) begin
            llc_op     <= 32'(head_op);
            llc_addr   <= head_addr;
            rcnt       <= rcnt + RW'(1);
            replay_cnt <= replay_cnt + 32'd1;
          end
          if (abandon) replay_err <= 1'b1;
        end
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_llc_req_sequencer.sv
// Bench for llc_req_sequencer: directed scenarios plus random traffic checked
// against a transaction-level queue model of the request stream.
module tb_llc_req_sequencer;

  localparam int unsigned DEPTH   = 8;
  localparam int unsigned MAXR    = 4;
  localparam int unsigned IDLE_OP = 7;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        in_valid, in_ready;
  logic [3:0]  in_op;
  logic [31:0] in_addr, llc_addr, llc_op, llc_hold;
  logic        print_req, busy, replay_err;
  logic [31:0] issue_cnt, replay_cnt, drop_cnt;

  always #5 clk = ~clk;

  llc_req_sequencer #(.DEPTH(DEPTH), .MAX_REPLAY(MAXR), .IDLE_OP(IDLE_OP)) dut (
    .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(in_ready),
    .in_op(in_op), .in_addr(in_addr), .llc_addr(llc_addr), .llc_op(llc_op),
    .llc_hold(llc_hold), .print_req(print_req), .busy(busy),
    .issue_cnt(issue_cnt), .replay_cnt(replay_cnt), .drop_cnt(drop_cnt),
    .replay_err(replay_err)
  );

  int n_chk, n_err, cyc, last_issue_cyc, c_push;
  int exp_issue, exp_replay, exp_drop, exp_prints, seen_prints, m_rcnt, hold_sel;
  logic exp_err, prev_nonidle;
  logic [35:0] q[$];
  logic [31:0] hold_pat[$];

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %h expected %h (cycle %0d)", tag, got, exp, cyc);
    end
  endtask

  function automatic bit is_req(input logic [3:0] op);
    return (op <= 4'd6) || (op == 4'd8);
  endfunction

  function automatic bit is_rpl(input logic [3:0] op);
    return (op == 4'd0) || (op == 4'd1) || (op == 4'd2) || (op == 4'd5);
  endfunction

  task automatic model_reset();
    q.delete();
    exp_issue = 0; exp_replay = 0; exp_drop = 0; exp_prints = 0;
    seen_prints = 0; m_rcnt = 0; exp_err = 1'b0;
  endtask

  // Prints and illegal ops ahead of the next request retire locally
  task automatic retire_nonreq();
    while (q.size() > 0 && !is_req(q[0][35:32])) begin
      if (q[0][35:32] == 4'd9) exp_prints++;
      else                     exp_drop++;
      void'(q.pop_front());
    end
  endtask

  // Called once per observed LLC request; picks the LLC's hold response
  task automatic handle_issue();
    logic [31:0] h;
    int r;
    retire_nonreq();
    exp_issue++;
    last_issue_cyc = cyc;
    if (q.size() == 0) begin
      chk("spurious_issue", llc_op, IDLE_OP);
      return;
    end
    chk("issue_op", llc_op, 32'(q[0][35:32]));
    chk("issue_addr", llc_addr, q[0][31:0]);
    case (hold_sel)
      1: h = 32'd1;
      2: h = 32'd0;
      3: h = (hold_pat.size() > 0) ? hold_pat.pop_front() : 32'd0;
      default: begin
        r = int'($urandom_range(0, 3));
        if (r == 0)      h = 32'd0;
        else if (r == 3) h = ($urandom_range(0, 1) == 1) ? 32'd2 : 32'hFFFF_FFFF;
        else             h = 32'd1;
      end
    endcase
    llc_hold = h;
    if (is_rpl(q[0][35:32]) && h == 32'd1) begin
      if (m_rcnt < int'(MAXR)) begin
        m_rcnt++;
        exp_replay++;
      end else begin
        exp_drop++;
        exp_err = 1'b1;
        m_rcnt = 0;
        void'(q.pop_front());
      end
    end else begin
      m_rcnt = 0;
      void'(q.pop_front());
    end
  endtask

  task automatic monitor();
    cyc++;
    if (print_req) seen_prints++;
    if (llc_op != IDLE_OP) begin
      chk("issue_gap", {31'b0, prev_nonidle}, 32'd0);
      prev_nonidle = 1'b1;
      handle_issue();
    end else begin
      prev_nonidle = 1'b0;
    end
  endtask

  task automatic cycle(input bit v, input logic [3:0] op, input logic [31:0] a);
    in_valid = v;
    in_op    = op;
    in_addr  = a;
    if (v && in_ready && rst_n) q.push_back({op, a});
    @(negedge clk);
    monitor();
  endtask

  task automatic idle(input int n);
    repeat (n) cycle(1'b0, 4'd0, 32'd0);
  endtask

  task automatic drain();
    int k;
    k = 0;
    while (busy && k < 300) begin
      idle(1);
      k++;
    end
    if (k >= 300) chk("drain_timeout", 32'(busy), 32'd0);
    idle(3);
  endtask

  task automatic final_check(input string ph);
    drain();
    retire_nonreq();
    chk({ph, "_leftover"}, 32'(q.size()), 32'd0);
    chk({ph, "_issue_cnt"}, issue_cnt, 32'(exp_issue));
    chk({ph, "_replay_cnt"}, replay_cnt, 32'(exp_replay));
    chk({ph, "_drop_cnt"}, drop_cnt, 32'(exp_drop));
    chk({ph, "_replay_err"}, 32'(replay_err), 32'(exp_err));
    chk({ph, "_prints"}, 32'(seen_prints), 32'(exp_prints));
    chk({ph, "_busy"}, 32'(busy), 32'd0);
    chk({ph, "_llc_op_idle"}, llc_op, IDLE_OP);
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1);
  end

  initial begin
    n_chk = 0; n_err = 0; cyc = 0; last_issue_cyc = 0; c_push = 0;
    rst_n = 1'b0; in_valid = 1'b0; in_op = '0; in_addr = '0; llc_hold = '0;
    hold_sel = 2; prev_nonidle = 1'b0;
    model_reset();
    @(negedge clk);
    idle(3);

    // Reset state
    chk("rst_llc_op", llc_op, IDLE_OP);
    chk("rst_llc_addr", llc_addr, 32'd0);
    chk("rst_in_ready", 32'(in_ready), 32'd0);
    chk("rst_busy", 32'(busy), 32'd0);
    chk("rst_print", 32'(print_req), 32'd0);
    chk("rst_issue", issue_cnt, 32'd0);
    chk("rst_replay", replay_cnt, 32'd0);
    chk("rst_drop", drop_cnt, 32'd0);
    chk("rst_err", 32'(replay_err), 32'd0);
    rst_n = 1'b1;
    idle(1);
    chk("post_rst_ready", 32'(in_ready), 32'd1);

    // Basic issue with push-to-present latency
    hold_sel = 2;
    cycle(1'b1, 4'd0, 32'h0000_1000);
    c_push = cyc;
    idle(4);
    chk("basic_latency", 32'(last_issue_cyc - c_push), 32'd1);
    final_check("basic");

    // Eviction replay: hold 1 after first issue, 0 after second
    hold_sel = 3;
    hold_pat.delete();
    hold_pat.push_back(32'd1);
    hold_pat.push_back(32'd0);
    cycle(1'b1, 4'd1, 32'hA000_0040);
    final_check("evict");

    // Replay cap, then a non-replaying op under permanent hold
    hold_sel = 1;
    cycle(1'b1, 4'd2, $urandom);
    final_check("cap");
    cycle(1'b1, 4'd3, $urandom);
    final_check("noreplay");

    // Print and drop filtering
    hold_sel = 2;
    cycle(1'b1, 4'd9, 32'h1111_0000);
    cycle(1'b1, 4'd7, 32'h2222_0000);
    cycle(1'b1, 4'd12, 32'h3333_0000);
    cycle(1'b1, 4'd0, 32'h4444_0000);
    final_check("prdrop");

    // Fill the FIFO while the LLC keeps rejecting
    hold_sel = 1;
    for (int i = 0; i < int'(DEPTH); i++) begin
      chk("full_ready_pre", 32'(in_ready), 32'd1);
      case ($urandom_range(0, 3))
        0:       cycle(1'b1, 4'd0, $urandom);
        1:       cycle(1'b1, 4'd1, $urandom);
        2:       cycle(1'b1, 4'd2, $urandom);
        default: cycle(1'b1, 4'd5, $urandom);
      endcase
    end
    chk("full_ready", 32'(in_ready), 32'd0);
    cycle(1'b1, 4'd0, 32'hDEAD_BEEF);
    final_check("full");

    // Random traffic with random hold responses
    hold_sel = 0;
    repeat (600) cycle($urandom_range(0, 9) < 6, 4'($urandom_range(0, 15)), $urandom);
    final_check("rand");

    // Reset asserted during CHECK with entries queued
    hold_sel = 2;
    llc_hold = 32'd0;
    cycle(1'b1, 4'd0, 32'h0000_5000);
    cycle(1'b1, 4'd0, 32'h0000_6000);
    cycle(1'b1, 4'd0, 32'h0000_7000);
    chk("mid_at_check", 32'(cyc - last_issue_cyc), 32'd1);
    rst_n = 1'b0;
    model_reset();
    idle(1);
    chk("mid_llc_op", llc_op, IDLE_OP);
    chk("mid_issue", issue_cnt, 32'd0);
    chk("mid_replay", replay_cnt, 32'd0);
    chk("mid_drop", drop_cnt, 32'd0);
    chk("mid_err", 32'(replay_err), 32'd0);
    chk("mid_busy", 32'(busy), 32'd0);
    chk("mid_ready", 32'(in_ready), 32'd0);
    rst_n = 1'b1;
    idle(20);
    chk("mid_post_issue", issue_cnt, 32'd0);
    chk("mid_post_busy", 32'(busy), 32'd0);
    chk("mid_post_ready", 32'(in_ready), 32'd1);

    $display("== %0d vectors applied, %0d miscompares ==", n_chk, n_err);
    $finish;
  end

endmodule
